// File: rtl/perceptron_trainer_n.sv
// perceptron_trainer_n: N-input perceptron trainer/classifier with saturating updates and epoch limit
module perceptron_trainer_n #(
    parameter int N_IN = 2,
    parameter int XW   = 7,
    parameter int WW   = 14,
    parameter int EPW  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          n_samples,
    input  logic [N_IN*XW-1:0]   x_in,
    input  logic [1:0]           t_in,
    input  logic                 data_ready,
    output logic                 request_flag,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic                 y_out,
    output logic                 y_valid,
    output logic [EPW-1:0]       epoch_count,
    output logic [N_IN*WW-1:0]   w_out,
    output logic [WW-1:0]        b_out
);
    localparam int AW = WW + XW + $clog2(N_IN + 1) + 1;
    localparam int SW = WW + XW + 1;
    localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam logic signed [SW-1:0] WMAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [SW-1:0] WMIN = ~WMAX;
    localparam logic signed [SW-1:0] ONE = 1;
    localparam logic [EPW-1:0] ELIM = {{(EPW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, REQ, MAC, UPDATE, EPOCH_END, DONE} state_t;

    state_t state, nxt;
    logic signed [WW-1:0] w [N_IN];
    logic signed [WW-1:0] nw [N_IN];
    logic signed [XW-1:0] xa [N_IN];
    logic signed [WW-1:0] b, nb;
    logic signed [AW-1:0] acc;
    logic signed [WW+XW-1:0] prod;
    logic [IW-1:0] idx;
    logic [31:0] cnt;
    logic t_neg, md, changed, last, wrong, unused;

    function automatic logic signed [WW-1:0] sat(input logic signed [SW-1:0] v);
        return v > WMAX ? WW'(WMAX) : v < WMIN ? WW'(WMIN) : WW'(v);
    endfunction

    assign unused = t_in[0];
    assign last = cnt == n_samples - 32'd1;
    assign wrong = acc[AW-1] ^ t_neg;
    assign request_flag = state == REQ;
    assign busy = !(state == IDLE || state == DONE);
    assign done = state == DONE;
    assign b_out = b;
    for (genvar i = 0; i < N_IN; i++) begin : g_w
        assign w_out[i*WW +: WW] = w[i];
    end

    // product for the current MAC step and the saturated candidate weights/bias
    always_comb begin
        prod = (WW+XW)'(w[idx]) * (WW+XW)'(xa[idx]);
        for (int i = 0; i < N_IN; i++)
            nw[i] = sat(t_neg ? SW'(w[i]) - SW'(xa[i]) : SW'(w[i]) + SW'(xa[i]));
        nb = sat(t_neg ? SW'(b) - ONE : SW'(b) + ONE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (start) nxt = n_samples == 32'd0 ? DONE : REQ;
            REQ:        if (data_ready) nxt = MAC;
            MAC:        if (idx == IW'(N_IN - 1)) nxt = UPDATE;
            UPDATE:     nxt = !last ? REQ : md ? DONE : EPOCH_END;
            EPOCH_END:  nxt = (!changed || epoch_count == ELIM) ? DONE : REQ;
            default:    nxt = IDLE;
        endcase
    end

    // datapath: sample capture, accumulation, weight update and epoch bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= '0;
                xa[i] <= '0;
            end
            b <= '0;
            acc <= '0;
            idx <= '0;
            cnt <= '0;
            t_neg <= 1'b0;
            md <= 1'b0;
            changed <= 1'b0;
            converged <= 1'b0;
            y_out <= 1'b0;
            y_valid <= 1'b0;
            epoch_count <= '0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    md <= mode;
                    cnt <= '0;
                    converged <= 1'b0;
                    if (!mode) begin
                        for (int i = 0; i < N_IN; i++) w[i] <= '0;
                        b <= '0;
                        epoch_count <= '0;
                        changed <= 1'b0;
                    end
                end
                REQ: if (data_ready) begin
                    for (int i = 0; i < N_IN; i++) xa[i] <= x_in[i*XW +: XW];
                    t_neg <= t_in[1];
                    acc <= AW'(b);
                    idx <= '0;
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    idx <= idx + IW'(1);
                end
                UPDATE: begin
                    y_out <= !acc[AW-1];
                    y_valid <= md;
                    if (!md && wrong) begin
                        w <= nw;
                        b <= nb;
                        changed <= 1'b1;
                    end
                    if (!last) cnt <= cnt + 32'd1;
                end
                EPOCH_END: begin
                    if (!changed) converged <= 1'b1;
                    else begin
                        epoch_count <= epoch_count + EPW'(1);
                        changed <= 1'b0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/perceptron_trainer_n.md
# perceptron_trainer_n

Parametrised perceptron training engine, the next generation of the two-input neuron. It supports N_IN inputs, configurable data and weight widths, saturating weight updates and an epoch limit. A classify mode reuses the trained weights to label a stream of samples. It sits between a sample source (testbench or sample memory sequencer) and downstream logic that consumes the learned weights and the classification results.

## Interface
- N_IN, 2, number of inputs per sample (≥1)
- XW, 7, signed input width
- WW, 14, signed weight/bias width
- EPW, 10, epoch counter width; MAX_EPOCH = 2^EPW − 1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  begin run; honoured only in IDLE or DONE
- mode  in  1  0 = train, 1 = classify; sampled with start
- n_samples  in  32  samples per epoch
- x_in  in  N_IN*XW  packed signed inputs; x_i = x_in[i*XW +: XW]
- t_in  in  2  target; t_in[1]=1 → −1, else +1
- data_ready  in  1  source has x_in/t_in valid
- request_flag  out  1  block requests a sample
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  run finished; held until next start/rst
- converged  out  1  valid with done; train run ended with an error-free epoch
- y_out  out  1  last decision, 1 = +1
- y_valid  out  1  one-cycle pulse in classify mode per sample
- epoch_count  out  EPW  completed epochs that had ≥1 update
- w_out  out  N_IN*WW  packed weights
- b_out  out  WW  bias

## Operation
- States: IDLE, REQ, MAC, UPDATE, EPOCH_END, DONE.
- IDLE/DONE + start:
  - Train: clear weights, bias, epoch_count, sample counter and changed flag, then go to REQ.
  - Classify: keep weights, clear the sample counter, then go to REQ.
  - n_samples = 0: go directly to DONE with converged = 0.
- start while busy: ignored.
- REQ: request_flag = 1. A cycle with data_ready = 1 captures x_in/t_in and moves to MAC. data_ready outside REQ is ignored.
- MAC: N_IN cycles, one product per cycle, acc = b + Σ w_i·x_i.
  - acc is exact signed, width WW+XW+⌈log2(N_IN+1)⌉+1, never overflows.
- UPDATE:
  - y = +1 if acc ≥ 0, else −1; y_out <= y.
  - Train, y ≠ t: w_i <= sat(w_i + t·x_i) and b <= sat(b + t) in parallel; set changed.
  - sat clamps to [−2^(WW−1), 2^(WW−1)−1].
  - Classify: y_valid pulses; no weight change.
  - Next state: sample counter = n_samples−1 → EPOCH_END (train) or DONE with converged = 0 (classify). Otherwise increment the counter and go to REQ.
- EPOCH_END (train only):
  - changed = 0 → DONE, converged = 1.
  - else epoch_count = MAX_EPOCH−1 → epoch_count++, DONE, converged = 0.
  - else epoch_count++, clear changed, clear sample counter, go to REQ.
- rst at any time: IDLE with all outputs zero on the next edge. An in-flight sample is discarded.

## Timing
- Reset values: all outputs 0; state IDLE.
- start sampled at edge E: request_flag = 1 from E+1.
- Capture at edge C (request_flag & data_ready):
  - request_flag = 0 from C+1.
  - MAC at C+1..C+N_IN; UPDATE at C+N_IN+1.
  - Weights/bias/y_out/y_valid visible from C+N_IN+2.
  - request_flag re-asserted at C+N_IN+2 (mid-epoch) or C+N_IN+3 (after EPOCH_END).
- done rises one cycle after the final UPDATE/EPOCH_END. It stays high, with weights stable, until start or rst.
- data_ready low in REQ: the block stalls indefinitely, no state change.

## Test plan
- Reset: assert rst 2 cycles mid-MAC → all outputs 0, IDLE. A later start restarts cleanly.
- AND set, N_IN=2, samples (1,1,+1), (1,−1,−1), (−1,1,−1), (−1,−1,−1) → done, converged = 1, epoch_count = 2, w = (1,1), b = −1.
- XOR set, EPW = 3 → done after 7 epochs, converged = 0, epoch_count = 7.
- Saturation, WW = 4, N_IN = 2, single sample (63,0,−1) → w1 = −8 (clamped), w2 = 0, b = −1, converged = 1, epoch_count = 1.
- Handshake:
  - data_ready low 5 cycles in REQ → request_flag stays 1, no capture.
  - data_ready pulsed during MAC → ignored.
  - Capture-to-next-request spacing = N_IN+2 cycles.
- Classify after AND training, inputs (1,1), (−1,1) → y_valid pulses twice, y_out = 1 then 0, weights unchanged, done with converged = 0.
